// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Tracks every in-flight register write across DEPTH post-decode stages and
//   resolves, at decode, where each source operand should be forwarded from.
//   Also detects load-use hazards where load data is not yet available.
//
//   Optional build macro: FWD_SCOREBOARD_STATS_EN adds two saturating 32-bit
//   activity counters (forwarded-decode cycles and stall cycles).
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset (priority over hold/flush)
//   hold            global freeze of the tracking table
//   flush           decode instruction is killed; a bubble enters stage 1
//   dec_valid       decode slot holds a real instruction
//   dec_src_addr    NUM_SRC packed source addresses, operand i at [i*ADDR_W +: ADDR_W]
//   dec_dst_addr    destination register of the decode instruction
//   dec_reg_write   decode instruction writes dec_dst_addr
//   dec_is_load     decode instruction is a load
//   fwd_sel         per operand: 0 = register file, k = forward from stage k
//   load_use_stall  decode must stall for one cycle
//   stat_fwd_count  (stats build) cycles that issued with at least one forward
//   stat_stall_count(stats build) cycles that stalled on a load-use hazard
module fwd_scoreboard #(
  parameter int  ADDR_W   = 5,
  parameter int  NUM_SRC  = 2,
  parameter int  DEPTH    = 3,
  parameter int  LOAD_LAT = 2,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        flush,
  input  logic                        dec_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   dec_src_addr,
  input  logic [ADDR_W-1:0]           dec_dst_addr,
  input  logic                        dec_reg_write,
  input  logic                        dec_is_load,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
`ifdef FWD_SCOREBOARD_STATS_EN
  output logic [31:0]                 stat_fwd_count,
  output logic [31:0]                 stat_stall_count,
`endif
  output logic                        load_use_stall
);

  // Index k-1 holds the instruction currently in stage k.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  load_q,  load_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];

  logic [ADDR_W-1:0] src;
  logic [SEL_W-1:0]  sel;
  logic              early_load;
  logic              any_early_load;

  // Scan oldest to youngest so the youngest matching writer is the last to
  // assign and therefore wins.
  always_comb begin
    fwd_sel        = '0;
    any_early_load = 1'b0;
    src            = '0;
    sel            = '0;
    early_load     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src        = dec_src_addr[i*ADDR_W +: ADDR_W];
      sel        = '0;
      early_load = 1'b0;
      if (src != '0) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (valid_q[k] && (addr_q[k] == src)) begin
            sel        = SEL_W'(k + 1);
            early_load = load_q[k] && ((k + 1) < LOAD_LAT);
          end
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = sel;
      any_early_load            = any_early_load | early_load;
    end
  end

  // Flush kills the decode instruction, so it cannot be waiting on anything.
  assign load_use_stall = dec_valid & ~flush & any_early_load;

  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    for (int k = 0; k < DEPTH; k++) addr_d[k] = addr_q[k];
    if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        addr_d[k]  = addr_q[k-1];
      end
      // Writes to x0 are never tracked; stalled or flushed slots become bubbles.
      valid_d[0] = dec_valid & dec_reg_write & (dec_dst_addr != '0) & ~flush & ~load_use_stall;
      load_d[0]  = dec_is_load;
      addr_d[0]  = dec_dst_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int k = 0; k < DEPTH; k++) addr_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      for (int k = 0; k < DEPTH; k++) addr_q[k] <= addr_d[k];
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (dec_valid && !hold && !load_use_stall && (fwd_sel != '0) && (fwd_cnt_q != '1))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    if (load_use_stall && !hold && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_fwd_count   = fwd_cnt_q;
  assign stat_stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-entry forwarding selector: tracks every in-flight register write across DEPTH post-decode stages.
- Resolves forwarding selects for NUM_SRC source operands at decode and detects load-use hazards.
- Also handles pipeline hold, flush bubbles, and multi-stage load latency.
- Sits beside the decode stage; its selects are latched into the ID/EX register with the operands.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 2, number of source operands resolved per cycle.
- DEPTH, 3, number of tracked post-decode stages (1 = EX, DEPTH = last stage before regfile write completes).
- LOAD_LAT, 2, first stage index at which load data can be forwarded; must satisfy 1 ≤ LOAD_LAT ≤ DEPTH.
- SEL_W, $clog2(DEPTH+1), select width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- hold  in  1  global freeze: table does not shift or insert.
- flush  in  1  current decode instruction is killed; bubble enters stage 1.
- dec_valid  in  1  decode slot holds a real instruction.
- dec_src_addr  in  NUM_SRC*ADDR_W  source register addresses; operand i at bits [i*ADDR_W +: ADDR_W].
- dec_dst_addr  in  ADDR_W  destination register.
- dec_reg_write  in  1  instruction writes dec_dst_addr.
- dec_is_load  in  1  instruction is a load.
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = forward from stage k.
- load_use_stall  out  1  decode must stall one cycle.

Behaviour:
- State: DEPTH entries {valid, addr, is_load}; entry k describes the instruction currently in stage k.
- Reset: all entries are invalid the cycle after rst. fwd_sel and load_use_stall are 0 whenever the table is empty. rst has priority over hold and flush.
- fwd_sel is combinational, same cycle, from the current dec_src_addr and the registered table:
  - Selects the smallest k (youngest writer) with valid[k] and addr[k] == src.
  - src == 0 always yields 0.
  - No match yields 0.
- load_use_stall = dec_valid & !flush & OR over operands of (the youngest match is a load at stage k < LOAD_LAT).
  - Raised during hold as well.
  - fwd_sel still reports k while stalled.
- Update on each rising clk edge when !rst && !hold:
  - Entry k+1 <= entry k for k = 1..DEPTH-1; entry DEPTH is discarded.
  - Entry 1 <= {1, dec_dst_addr, dec_is_load} iff dec_valid & dec_reg_write & dec_dst_addr != 0 & !flush & !load_use_stall; otherwise entry 1 becomes invalid (bubble).
- hold: table is frozen; outputs keep tracking the live decode inputs.
- flush and load_use_stall in the same cycle: a single bubble is inserted; flush masks the stall.
- Same destination in several stages: the youngest always wins. Older duplicates age out normally; no dedup is needed.
- A load at stage ≥ LOAD_LAT forwards normally with no stall.
- With LOAD_LAT = 1, the block never stalls.
- Reset mid-operation clears all entries regardless of hold or flush.

Optional Feature:
- Macro: FWD_SCOREBOARD_STATS_EN.
- When defined, two extra outputs, each 32 bits, zero on rst, saturating at all-ones:
  - stat_fwd_count: counts cycles with dec_valid & !hold & !load_use_stall & any fwd_sel != 0.
  - stat_stall_count: counts cycles with load_use_stall & !hold.
- When undefined: neither port nor counter exists, and the behaviour is otherwise identical.

Test Plan:
1. Reset, then dec_src_addr = {x5, x6} with an empty table -> fwd_sel = {0, 0}, load_use_stall = 0; one cycle after rst all entries read invalid.
2. Non-load writes x5 inserted, next cycle decode reads x5 -> fwd_sel = 1; each later cycle with no hold, it reads 2, then 3, then 0 (DEPTH = 3).
3. Load to x7, then the next instruction reads x7 as src1 -> load_use_stall = 1 for exactly one cycle while entry 1 becomes a bubble. Next cycle load_use_stall = 0 and fwd_sel for that operand = 2.
4. Writes to x9 in consecutive cycles (stages 2 and 1), then decode reads x9 -> fwd_sel = 1 (youngest wins); src = x0 with any entry addr 0 -> fwd_sel = 0.
5. x4 writer in stage 1, hold = 1 for 3 cycles -> fwd_sel for x4 stays 1 throughout. Writer asserted with flush = 1 -> never inserted; a later reader gets 0.
6. With FWD_SCOREBOARD_STATS_EN defined, run scenarios 2 and 3 -> stat_fwd_count and stat_stall_count match the hand-counted cycles; rst zeroes both.
